// File: rtl/counter_arbiter.sv
// -----------------------------------------------------------------------------
// counter_arbiter
//
// Round-robin arbiter and sequencer that shares one 4-bit up-counter among
// NREQ requesters. Each requester asks for an interval of 0..15 counts.
//
// The block does four things:
//   - grants the counter to one requester at a time;
//   - clears the counter and then enables it;
//   - stops the count when the counter output equals the latched length;
//   - pulses done to the owner when the count is reached.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   req         in   per-requester request level, held until done or abort
//   req_len     in   NREQ 4-bit lengths, requester i at [4i+3:4i], sampled at grant
//   cnt_value   in   shared counter output
//   cnt_reset   out  drives counter reset pin (CLEAR state)
//   cnt_enable  out  drives counter enable pin (COUNT state, below target)
//   grant       out  one-hot owner of the counter, registered
//   done        out  one-cycle completion pulse to the owner, registered
//   busy        out  high whenever the state is not IDLE
// -----------------------------------------------------------------------------
module counter_arbiter #(
  parameter int NREQ = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_len,
  input  logic [3:0]        cnt_value,
  output logic              cnt_reset,
  output logic              cnt_enable,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_COUNT,
    S_FINISH
  } state_t;

  state_t            state_q;
  logic [IW-1:0]     rr_ptr_q;
  logic [IW-1:0]     owner_q;
  logic [3:0]        len_q;
  logic [NREQ-1:0]   grant_q;
  logic [NREQ-1:0]   done_q;

  logic [IW-1:0]     win_idx;
  logic              win_valid;
  logic [IW-1:0]     cand;
  logic [IW-1:0]     rr_next;

  // Round-robin search starting at rr_ptr_q. The loop walks the offsets from
  // highest to lowest so the last hit, which is the nearest to the pointer,
  // wins without needing a break. Index wrap relies on NREQ being a power of 2.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = rr_ptr_q + IW'(k);
      if (req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign rr_next = owner_q + IW'(1);

  // A single FSM process holds all state, so grant and done come straight out
  // of flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      len_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
    end else begin
      // NOTE: non-blocking throughout; done defaults low so it is a one-cycle pulse.
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (win_valid) begin
            owner_q <= win_idx;
            len_q   <= req_len[4*win_idx +: 4];
            grant_q <= NREQ'(1) << win_idx;
            state_q <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (req[owner_q]) begin
            state_q <= S_COUNT;
          end else begin
            // The requester withdrew before counting began, so it loses its turn.
            grant_q  <= '0;
            rr_ptr_q <= rr_next;
            state_q  <= S_IDLE;
          end
        end
        S_COUNT: begin
          if (!req[owner_q]) begin
            grant_q  <= '0;
            rr_ptr_q <= rr_next;
            state_q  <= S_IDLE;
          end else if (cnt_value == len_q) begin
            done_q  <= grant_q;
            state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          grant_q  <= '0;
          rr_ptr_q <= rr_next;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The counter pins are decoded from the state so the counter reacts in the
  // same cycle. Enable drops the cycle the target is seen, so the counter
  // stops exactly at len_q and never wraps.
  assign cnt_reset  = (state_q == S_CLEAR);
  assign cnt_enable = (state_q == S_COUNT) && (cnt_value != len_q);
  assign busy       = (state_q != S_IDLE);
  assign grant      = grant_q;
  assign done       = done_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// -----------------------------------------------------------------------------
// tb_counter_arbiter
//
// Bench for counter_arbiter. It contains a behavioural model of the shared
// 4-bit counter, which closes the cnt_reset/cnt_enable -> cnt_value loop.
//
// Each accepted request pushes its expected done vector and final count onto a
// scoreboard. A negedge monitor pops the scoreboard on every done pulse.
// Directed sequences check cycle timing, abort, reset and round-robin order.
// -----------------------------------------------------------------------------
module tb_counter_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] req_len;
  logic [3:0]  cnt_value;
  logic        cnt_reset;
  logic        cnt_enable;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;

  always #5 clock = ~clock;

  counter_arbiter #(.NREQ(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .req_len    (req_len),
    .cnt_value  (cnt_value),
    .cnt_reset  (cnt_reset),
    .cnt_enable (cnt_enable),
    .grant      (grant),
    .done       (done),
    .busy       (busy)
  );

  // Shared counter: the system reset or cnt_reset clears it, and cnt_enable
  // makes it count up.
  always @(posedge clock) begin
    if (reset || cnt_reset) cnt_value <= 4'd0;
    else if (cnt_enable)    cnt_value <= cnt_value + 4'd1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0] done_vec;
    logic [3:0] final_cnt;
  } exp_t;

  exp_t sb[$];
  bit   mon_en = 1'b0;
  int   overlap_cnt = 0;

  // Scoreboard monitor. On a done pulse it checks the owner and the count at
  // which the counter stopped.
  always @(negedge clock) begin
    exp_t e;
    if (mon_en) begin
      if (cnt_reset && cnt_enable) overlap_cnt++;
      if (done !== 4'b0000) begin
        if (sb.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          e = sb.pop_front();
          check("done_vec", done, e.done_vec);
          check("done_cnt", cnt_value, e.final_cnt);
        end
      end
    end
  end

  task automatic step();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    step();
    step();
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_en", cnt_enable, 0);
    check("rst_clr", cnt_reset, 0);
    reset = 1'b0;
  endtask

  // One requester and one interval. Cycle 1 is CLEAR and done is due in cycle
  // 3+len. With mangle set, the requester's length slice changes mid-count.
  task automatic run_single(input int i, input logic [3:0] len, input bit mangle);
    int         c;
    int         en;
    int         done_c;
    logic [3:0] oh;
    oh      = 4'(1 << i);
    req_len = 16'($urandom);
    req_len[4*i +: 4] = len;
    req     = oh;
    sb.push_back({oh, len});
    step();
    c = 1;
    check("clr_grant", grant, oh);
    check("clr_reset", cnt_reset, 1);
    check("clr_en", cnt_enable, 0);
    en     = 0;
    done_c = -1;
    while (c < 40 && done_c < 0) begin
      step();
      c++;
      if (mangle && c == 3) req_len[4*i +: 4] = ~len;
      if (cnt_enable) en++;
      if (done !== 4'b0000) done_c = c;
    end
    check("done_cycle", done_c, 3 + int'(len));
    check("en_cycles", en, len);
    check("fin_grant", grant, oh);
    req = 4'b0000;
    step();
    check("idle_busy", busy, 0);
    check("idle_grant", grant, 0);
    check("idle_cnt", cnt_value, len);
  endtask

  logic [3:0] rr_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin : main
    int c;
    int ng;
    int nd;
    bit got;
    logic [3:0] prev;

    reset   = 1'b1;
    req     = 4'b0000;
    req_len = 16'h0000;
    do_reset();
    mon_en = 1'b1;

    // Basic intervals, the length boundaries and a length change after grant.
    run_single(0, 4'd5, 1'b0);
    run_single(0, 4'd0, 1'b0);
    run_single(1, 4'd15, 1'b0);
    run_single(2, 4'd7, 1'b1);
    run_single(3, 4'd3, 1'b0);

    // Round-robin fairness with all four requesters held high.
    do_reset();
    req_len = 16'h2222;
    req     = 4'b1111;
    for (int k = 0; k < 5; k++) sb.push_back({rr_order[k], 4'd2});
    ng = 0; nd = 0; c = 0; prev = 4'b0000;
    while (nd < 5 && c < 100) begin
      step();
      c++;
      if (grant !== 4'b0000 && prev === 4'b0000) begin
        if (ng < 5) check("rr_grant", grant, rr_order[ng]);
        ng++;
      end
      prev = grant;
      if (done !== 4'b0000) begin
        nd++;
        if (nd == 5) req = 4'b0000;
      end
    end
    check("rr_dones", nd, 5);
    check("rr_grants", ng, 5);
    step();
    check("rr_idle", busy, 0);

    // Abort: requester 2 drops its request in its third COUNT cycle while
    // requester 3 is waiting.
    do_reset();
    req_len = 16'h3600;
    req     = 4'b1100;
    step();
    check("ab_grant", grant, 4'b0100);
    step();
    step();
    step();
    check("ab_en", cnt_enable, 1);
    check("ab_cnt4", cnt_value, 2);
    req = 4'b1000;
    step();
    check("ab_grant_clr", grant, 0);
    check("ab_done", done, 0);
    check("ab_cnt5", cnt_value, 3);
    check("ab_en_off", cnt_enable, 0);
    check("ab_busy", busy, 0);
    step();
    check("ab_next_grant", grant, 4'b1000);
    check("ab_cnt_frozen", cnt_value, 3);
    sb.push_back({4'b1000, 4'd3});
    got = 1'b0;
    c   = 0;
    while (!got && c < 30) begin
      step();
      c++;
      if (done !== 4'b0000) begin
        got = 1'b1;
        req = 4'b0000;
      end
    end
    check("ab_next_done", got, 1);
    step();

    // Reset asserted mid-COUNT with L=10, then the first grant is checked.
    req_len = 16'h00A0;
    req     = 4'b0010;
    for (int k = 0; k < 6; k++) step();
    check("mr_counting", cnt_enable, 1);
    reset = 1'b1;
    step();
    check("mr_grant", grant, 0);
    check("mr_done", done, 0);
    check("mr_busy", busy, 0);
    check("mr_en", cnt_enable, 0);
    check("mr_clr", cnt_reset, 0);
    check("mr_cnt", cnt_value, 0);
    reset   = 1'b0;
    req     = 4'b1111;
    req_len = 16'h1111;
    step();
    check("mr_first_grant", grant, 4'b0001);
    // All requests withdraw during CLEAR, which aborts with no done.
    req = 4'b0000;
    step();
    check("mr_abort_grant", grant, 0);
    check("mr_abort_busy", busy, 0);
    step();

    check("no_overlap", overlap_cnt, 0);
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
